// File: rtl/divider_mem_ctrl.sv
// Sequences scratch-memory reads, divider dispatch and result writes for the hist-eq divide stage.
// Latency: 5 cycles minimum per iteration plus 1 DONE cycle; outputs registered, strobes masked by abort.
// Backpressure: stalls in RD_WAIT until read data is ready and in DIV_WAIT until all dividers finish or time out.
module divider_mem_ctrl #(
    parameter int                ADDR_W      = 8,
    parameter int                NUM_ITER    = 32,
    parameter logic [ADDR_W-1:0] RD_BASE     = 'h00,
    parameter logic [ADDR_W-1:0] WT_BASE     = 'h80,
    parameter int                DIV_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    output logic              sc_mem_rd_en,
    output logic [ADDR_W-1:0] sc_mem_rd_addr1,
    output logic [ADDR_W-1:0] sc_mem_rd_addr2,
    input  logic              sc_mem_rd_data_rdy,
    output logic              dp_enable,
    output logic              div_start,
    input  logic [7:0]        div_done,
    output logic              sc_mem_wt_en,
    output logic [ADDR_W-1:0] sc_mem_wt_addr,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int ITER_W = (NUM_ITER > 1) ? $clog2(NUM_ITER) : 1;
    localparam int TMO_W  = (DIV_TIMEOUT > 1) ? $clog2(DIV_TIMEOUT) : 1;
    localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(NUM_ITER - 1);
    localparam logic [TMO_W-1:0]  TMO_MAX   = TMO_W'(DIV_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_DISPATCH,
        S_DIV_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t            state;
    logic [ITER_W-1:0] iter;
    logic [7:0]        done_seen;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              rd_en_q;
    logic              div_start_q;
    logic              wt_en_q;
    logic              done_q;

    logic [ADDR_W-1:0] iter_a;
    logic [ADDR_W-1:0] nxt_rd_addr1;
    logic              all_done;

    assign iter_a       = ADDR_W'(iter);
    assign nxt_rd_addr1 = RD_BASE + ((iter_a + ADDR_W'(1)) << 1);
    assign all_done     = ((done_seen | div_done) == 8'hFF);

    // An abort must suppress any strobe in the very cycle it is raised.
    assign sc_mem_rd_en = rd_en_q & ~abort;
    assign div_start    = div_start_q & ~abort;
    assign sc_mem_wt_en = wt_en_q & ~abort;
    assign done         = done_q & ~abort;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= S_IDLE;
            iter            <= '0;
            done_seen       <= '0;
            tmo_cnt         <= '0;
            rd_en_q         <= 1'b0;
            div_start_q     <= 1'b0;
            wt_en_q         <= 1'b0;
            done_q          <= 1'b0;
            sc_mem_rd_addr1 <= '0;
            sc_mem_rd_addr2 <= '0;
            sc_mem_wt_addr  <= '0;
            dp_enable       <= 1'b0;
            busy            <= 1'b0;
            err             <= 1'b0;
        end else begin
            rd_en_q     <= 1'b0;
            div_start_q <= 1'b0;
            wt_en_q     <= 1'b0;
            done_q      <= 1'b0;
            if (abort) begin
                state     <= S_IDLE;
                busy      <= 1'b0;
                dp_enable <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            state           <= S_RD_REQ;
                            iter            <= '0;
                            err             <= 1'b0;
                            busy            <= 1'b1;
                            rd_en_q         <= 1'b1;
                            sc_mem_rd_addr1 <= RD_BASE;
                            sc_mem_rd_addr2 <= RD_BASE + ADDR_W'(1);
                        end
                    end
                    S_RD_REQ: begin
                        state     <= S_RD_WAIT;
                        dp_enable <= 1'b1;
                    end
                    S_RD_WAIT: begin
                        if (sc_mem_rd_data_rdy) begin
                            state       <= S_DISPATCH;
                            div_start_q <= 1'b1;
                        end
                    end
                    S_DISPATCH: begin
                        state     <= S_DIV_WAIT;
                        done_seen <= '0;
                        tmo_cnt   <= '0;
                    end
                    S_DIV_WAIT: begin
                        done_seen <= done_seen | div_done;
                        if (all_done) begin
                            state          <= S_WRITE;
                            wt_en_q        <= 1'b1;
                            sc_mem_wt_addr <= WT_BASE + iter_a;
                        end else if (tmo_cnt == TMO_MAX) begin
                            state     <= S_DONE;
                            err       <= 1'b1;
                            done_q    <= 1'b1;
                            dp_enable <= 1'b0;
                        end else begin
                            tmo_cnt <= tmo_cnt + TMO_W'(1);
                        end
                    end
                    S_WRITE: begin
                        dp_enable <= 1'b0;
                        if (iter == LAST_ITER) begin
                            state  <= S_DONE;
                            done_q <= 1'b1;
                        end else begin
                            state           <= S_RD_REQ;
                            iter            <= iter + ITER_W'(1);
                            rd_en_q         <= 1'b1;
                            sc_mem_rd_addr1 <= nxt_rd_addr1;
                            sc_mem_rd_addr2 <= nxt_rd_addr1 + ADDR_W'(1);
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_divider_mem_ctrl.sv
// Directed bench for divider_mem_ctrl, run with NUM_ITER=4 so an abort in the fourth pass can be exercised.
module tb_divider_mem_ctrl;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b1;
    logic       start   = 1'b0;
    logic       abort   = 1'b0;
    logic       rdy     = 1'b0;
    logic [7:0] div_done = 8'h00;

    logic       rd_en, dp_enable, div_start, wt_en, busy, done, err;
    logic [7:0] addr1, addr2, wt_addr;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t0    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    divider_mem_ctrl #(
        .ADDR_W     (8),
        .NUM_ITER   (4),
        .RD_BASE    (8'h00),
        .WT_BASE    (8'h80),
        .DIV_TIMEOUT(64)
    ) u_dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .start             (start),
        .abort             (abort),
        .sc_mem_rd_en      (rd_en),
        .sc_mem_rd_addr1   (addr1),
        .sc_mem_rd_addr2   (addr2),
        .sc_mem_rd_data_rdy(rdy),
        .dp_enable         (dp_enable),
        .div_start         (div_start),
        .div_done          (div_done),
        .sc_mem_wt_en      (wt_en),
        .sc_mem_wt_addr    (wt_addr),
        .busy              (busy),
        .done              (done),
        .err               (err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {1'b0, rd_en, addr1, addr2, dp_enable, div_start, wt_en, wt_addr, busy, done, err};
    endfunction

    // One minimum-length pass, entered in RD_REQ; leaves the bench in the following state.
    task automatic fast_iter(input int it);
        chk("rd_en", rd_en, 1);
        chk("rd_addr1", addr1, 2 * it);
        chk("rd_addr2", addr2, 2 * it + 1);
        chk("dp_off_rdreq", dp_enable, 0);
        step();
        chk("rd_en_1cyc", rd_en, 0);
        chk("dp_on", dp_enable, 1);
        rdy = 1'b1;
        step();
        rdy = 1'b0;
        chk("div_start", div_start, 1);
        step();
        div_done = 8'hFF;
        chk("div_start_1cyc", div_start, 0);
        chk("wt_early", wt_en, 0);
        step();
        div_done = 8'h00;
        chk("wt_en", wt_en, 1);
        chk("wt_addr", wt_addr, 8'h80 + it);
        step();
    endtask

    initial begin
        #2 reset_n = 1'b0;
        step();
        chk("reset_outs", all_outs(), 0);
        @(negedge clk) reset_n = 1'b1;
        step();
        chk("idle_outs", all_outs(), 0);

        // Full four-pass run at minimum latency.
        start = 1'b1;
        step();
        start = 1'b0;
        t0 = cyc;
        chk("busy_set", busy, 1);
        for (int it = 0; it < 4; it++) fast_iter(it);
        chk("done_pulse", done, 1);
        chk("done_latency", cyc - t0, 20);
        chk("done_busy", busy, 1);
        chk("done_err", err, 0);
        chk("done_dp", dp_enable, 0);
        step();
        chk("done_1cyc", done, 0);
        chk("busy_clr", busy, 0);

        // start and abort together in IDLE: abort wins.
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        chk("sa_busy", busy, 0);
        chk("sa_rd_en", rd_en, 0);
        step();
        chk("sa_rd_en2", rd_en, 0);

        // Slow read, stale done bits in DISPATCH, staggered done pulses.
        start = 1'b1;
        step();
        start = 1'b0;
        chk("stag_rd_en", rd_en, 1);
        step();
        repeat (2) begin
            chk("rd_wait_hold", div_start, 0);
            chk("rd_wait_addr", addr2, 1);
            step();
        end
        rdy = 1'b1;
        step();
        rdy = 1'b0;
        chk("stag_div_start", div_start, 1);
        div_done = 8'hFF;
        step();
        for (int k = 1; k <= 7; k++) begin
            div_done = (k == 2) ? 8'h0F : ((k == 7) ? 8'hF0 : 8'h00);
            chk("stag_no_early_wt", wt_en, 0);
            step();
        end
        div_done = 8'h00;
        chk("stag_wt_en", wt_en, 1);
        chk("stag_wt_addr", wt_addr, 8'h80);
        step();
        fast_iter(1);
        fast_iter(2);

        // Abort in DIV_WAIT of the fourth pass, with all done bits present.
        chk("it3_addr1", addr1, 8'h06);
        chk("it3_addr2", addr2, 8'h07);
        step();
        rdy = 1'b1;
        step();
        rdy = 1'b0;
        step();
        abort = 1'b1;
        div_done = 8'hFF;
        chk("abort_wt_cycle", wt_en, 0);
        step();
        abort = 1'b0;
        div_done = 8'h00;
        chk("abort_busy", busy, 0);
        chk("abort_dp", dp_enable, 0);
        chk("abort_err", err, 0);
        repeat (3) begin
            chk("abort_no_wt_done", {wt_en, done}, 0);
            step();
        end

        // Restart from iter 0, then hold 7 of 8 done bits until timeout.
        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart_addr1", addr1, 8'h00);
        chk("restart_addr2", addr2, 8'h01);
        step();
        rdy = 1'b1;
        step();
        rdy = 1'b0;
        chk("tmo_div_start", div_start, 1);
        step();
        div_done = 8'h7F;
        for (int k = 1; k <= 64; k++) begin
            chk("tmo_wait", {wt_en, done, err}, 0);
            step();
        end
        chk("tmo_done", done, 1);
        chk("tmo_err", err, 1);
        chk("tmo_no_wt", wt_en, 0);
        div_done = 8'h00;
        step();
        chk("tmo_err_sticky", err, 1);
        chk("tmo_busy_clr", busy, 0);

        // Read-ready and done bits in IDLE are ignored.
        rdy = 1'b1;
        div_done = 8'hFF;
        step();
        step();
        chk("idle_ignore", {rd_en, div_start, dp_enable, busy, wt_en}, 0);
        rdy = 1'b0;
        div_done = 8'h00;

        // Next accepted start clears err; start while busy is ignored.
        start = 1'b1;
        step();
        start = 1'b0;
        chk("err_clr", err, 0);
        chk("busy_again", busy, 1);
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("busy_start_rd_en", rd_en, 0);
        chk("busy_start_addr", addr1, 8'h00);
        chk("busy_start_dp", dp_enable, 1);

        // Asynchronous reset mid-cycle in RD_WAIT.
        #3 reset_n = 1'b0;
        #1;
        chk("async_rst", all_outs(), 0);
        @(negedge clk) reset_n = 1'b1;
        step();
        chk("post_rst_idle", all_outs(), 0);
        start = 1'b1;
        step();
        start = 1'b0;
        t0 = cyc;
        for (int it = 0; it < 4; it++) fast_iter(it);
        chk("post_rst_done", done, 1);
        chk("post_rst_latency", cyc - t0, 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
